// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - registered operand selection with forwarding and valid/ready slice
// Optional OPERAND_SKID_EN adds a second (skid) entry so in_ready is a pure register output.
module operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int PC_INC  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              operand_ASel,
    input  logic [2:0]              operand_BSel,
    input  logic [XLEN-1:0]         pc,
    input  logic [4:0]              rs1_addr,
    input  logic [4:0]              rs2_addr,
    input  logic [XLEN-1:0]         rs1,
    input  logic [XLEN-1:0]         rs2,
    input  logic [XLEN-1:0]         itype_imm,
    input  logic [XLEN-1:0]         utype_imm,
    input  logic [XLEN-1:0]         stype_imm,
    input  logic [XLEN-1:0]         sbtype_imm,
    input  logic [XLEN-1:0]         ujtype_imm,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [5*NUM_FWD-1:0]    fwd_addr,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         operand_A,
    output logic [XLEN-1:0]         operand_B,
    output logic [XLEN-1:0]         store_data,
    output logic [XLEN-1:0]         out_pc
);

    localparam logic [XLEN-1:0] PC_INC_W = XLEN'(PC_INC);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] sd;
        logic [XLEN-1:0] pc;
    } ops_t;

    logic [XLEN-1:0] src1, src2;
    ops_t            ops_new;
    ops_t            out_q;
    logic            valid_q, valid_d;
    logic            accept;
    logic            load_out;

    // Walk channels oldest to youngest so the lowest-indexed match is written last and wins.
    always_comb begin
        src1 = rs1;
        src2 = rs2;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (rs1_addr != 5'd0) && (fwd_addr[5*i +: 5] == rs1_addr))
                src1 = fwd_data[XLEN*i +: XLEN];
            if (fwd_valid[i] && (rs2_addr != 5'd0) && (fwd_addr[5*i +: 5] == rs2_addr))
                src2 = fwd_data[XLEN*i +: XLEN];
        end
    end

    always_comb begin
        ops_new    = '0;
        ops_new.sd = src2;
        ops_new.pc = pc;
        case (operand_ASel)
            2'b00:   ops_new.a = src1;
            2'b01:   ops_new.a = pc;
            2'b10:   ops_new.a = pc + PC_INC_W;
            default: ops_new.a = '0;
        endcase
        case (operand_BSel)
            3'd0:    ops_new.b = src2;
            3'd1:    ops_new.b = itype_imm;
            3'd2:    ops_new.b = utype_imm;
            3'd3:    ops_new.b = stype_imm;
            3'd4:    ops_new.b = sbtype_imm;
            3'd5:    ops_new.b = ujtype_imm;
            default: ops_new.b = '0;
        endcase
    end

`ifdef OPERAND_SKID_EN
    ops_t skid_q;
    logic skid_valid_q, skid_valid_d;
    logic out_from_skid, load_skid;

    always_comb begin
        in_ready      = !skid_valid_q;
        accept        = in_valid && in_ready && !flush;
        valid_d       = valid_q;
        skid_valid_d  = skid_valid_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!valid_q || out_ready) begin
            // Output slot frees up: the parked entry is older than anything arriving now.
            if (skid_valid_q) begin
                out_from_skid = 1'b1;
                skid_valid_d  = 1'b0;
                valid_d       = 1'b1;
            end else if (accept) begin
                load_out = 1'b1;
                valid_d  = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            if (load_skid)
                skid_q <= ops_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (out_from_skid) begin
            out_q <= skid_q;
        end else if (load_out) begin
            out_q <= ops_new;
        end
    end
`else
    always_comb begin
        in_ready = !valid_q || out_ready;
        accept   = in_valid && in_ready && !flush;
        valid_d  = valid_q;
        load_out = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            load_out = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (load_out) begin
            out_q <= ops_new;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= 1'b0;
        else
            valid_q <= valid_d;
    end

    assign out_valid  = valid_q;
    assign operand_A  = out_q.a;
    assign operand_B  = out_q.b;
    assign store_data = out_q.sd;
    assign out_pc     = out_q.pc;

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - directed table, corner sequences and randomized queue-model check
module tb_operand_stage;

`ifdef OPERAND_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  operand_ASel = '0;
    logic [2:0]  operand_BSel = '0;
    logic [31:0] pc = '0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [31:0] itype_imm = '0, utype_imm = '0, stype_imm = '0, sbtype_imm = '0, ujtype_imm = '0;
    logic [1:0]  fwd_valid = '0;
    logic [9:0]  fwd_addr = '0;
    logic [63:0] fwd_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] operand_A, operand_B, store_data, out_pc;

    operand_stage #(.XLEN(32), .NUM_FWD(2), .PC_INC(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand_ASel(operand_ASel), .operand_BSel(operand_BSel), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1(rs1), .rs2(rs2),
        .itype_imm(itype_imm), .utype_imm(utype_imm), .stype_imm(stype_imm),
        .sbtype_imm(sbtype_imm), .ujtype_imm(ujtype_imm),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .operand_A(operand_A), .operand_B(operand_B), .store_data(store_data), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  asel;
        logic [2:0]  bsel;
        logic [31:0] pc;
        logic [4:0]  rs1a, rs2a;
        logic [31:0] rs1, rs2;
        logic [31:0] ii, ui, si, sbi, uji;
        logic [1:0]  fv;
        logic [9:0]  fa;
        logic [63:0] fd;
        logic [31:0] exp_a, exp_b, exp_sd;
    } vec_t;

    typedef struct {
        logic [31:0] a, b, sd, pc;
    } ops_t;

    vec_t tbl[12];
    ops_t mq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t base();
        vec_t v;
        v.asel = 2'd0; v.bsel = 3'd0; v.pc = 32'h1000;
        v.rs1a = 5'd1; v.rs2a = 5'd2; v.rs1 = 32'h0; v.rs2 = 32'h0;
        v.ii = 32'h111; v.ui = 32'h222; v.si = 32'h333; v.sbi = 32'h444; v.uji = 32'h555;
        v.fv = 2'b00; v.fa = 10'd0; v.fd = 64'd0;
        v.exp_a = 32'h0; v.exp_b = 32'h0; v.exp_sd = 32'h0;
        return v;
    endfunction

    task automatic drive_vec(input vec_t v);
        operand_ASel = v.asel; operand_BSel = v.bsel; pc = v.pc;
        rs1_addr = v.rs1a; rs2_addr = v.rs2a; rs1 = v.rs1; rs2 = v.rs2;
        itype_imm = v.ii; utype_imm = v.ui; stype_imm = v.si; sbtype_imm = v.sbi; ujtype_imm = v.uji;
        fwd_valid = v.fv; fwd_addr = v.fa; fwd_data = v.fd;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".A"}, operand_A, v.exp_a);
        check({tag, ".B"}, operand_B, v.exp_b);
        check({tag, ".sd"}, store_data, v.exp_sd);
        check({tag, ".pc"}, out_pc, v.pc);
    endtask

    // Reference: first valid channel (lowest index) whose address matches, x0 never forwarded.
    function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return rf;
        for (int i = 0; i < 2; i++)
            if (fwd_valid[i] && fwd_addr[5*i +: 5] == a) return fwd_data[32*i +: 32];
        return rf;
    endfunction

    function automatic ops_t ref_ops();
        ops_t o;
        logic [31:0] s1, s2;
        s1 = resolve(rs1_addr, rs1);
        s2 = resolve(rs2_addr, rs2);
        case (operand_ASel)
            2'd0: o.a = s1;
            2'd1: o.a = pc;
            2'd2: o.a = pc + 32'd4;
            default: o.a = 32'd0;
        endcase
        case (operand_BSel)
            3'd0: o.b = s2;
            3'd1: o.b = itype_imm;
            3'd2: o.b = utype_imm;
            3'd3: o.b = stype_imm;
            3'd4: o.b = sbtype_imm;
            3'd5: o.b = ujtype_imm;
            default: o.b = 32'd0;
        endcase
        o.sd = s2;
        o.pc = pc;
        return o;
    endfunction

    initial begin
        bit   m_ready, m_push;
        ops_t f;

        tbl[0] = base(); tbl[0].rs1 = 5; tbl[0].rs2 = 7;
        tbl[0].exp_a = 5; tbl[0].exp_b = 7; tbl[0].exp_sd = 7;
        tbl[1] = base(); tbl[1].rs1a = 3; tbl[1].rs1 = 32'h11; tbl[1].rs2a = 4; tbl[1].rs2 = 32'h22;
        tbl[1].fv = 2'b11; tbl[1].fa = {5'd3, 5'd3}; tbl[1].fd = {32'hBB, 32'hAA};
        tbl[1].exp_a = 32'hAA; tbl[1].exp_b = 32'h22; tbl[1].exp_sd = 32'h22;
        tbl[2] = tbl[1]; tbl[2].fv = 2'b10; tbl[2].exp_a = 32'hBB;
        tbl[3] = base(); tbl[3].rs1a = 0; tbl[3].rs1 = 32'h11; tbl[3].rs2a = 0; tbl[3].rs2 = 32'h33;
        tbl[3].fv = 2'b11; tbl[3].fa = 10'd0; tbl[3].fd = {32'hBB, 32'hAA};
        tbl[3].exp_a = 32'h11; tbl[3].exp_b = 32'h33; tbl[3].exp_sd = 32'h33;
        tbl[4] = base(); tbl[4].pc = 32'h100; tbl[4].asel = 2; tbl[4].bsel = 5; tbl[4].uji = 32'h20;
        tbl[4].rs2 = 32'h44; tbl[4].exp_a = 32'h104; tbl[4].exp_b = 32'h20; tbl[4].exp_sd = 32'h44;
        tbl[5] = base(); tbl[5].pc = 32'hFFFFFFFC; tbl[5].asel = 2; tbl[5].bsel = 1; tbl[5].ii = 32'hFFFFF800;
        tbl[5].exp_a = 32'h0; tbl[5].exp_b = 32'hFFFFF800;
        tbl[6] = base(); tbl[6].pc = 32'h2000; tbl[6].asel = 1; tbl[6].bsel = 2; tbl[6].ui = 32'h12345000;
        tbl[6].exp_a = 32'h2000; tbl[6].exp_b = 32'h12345000;
        tbl[7] = base(); tbl[7].asel = 3; tbl[7].rs1 = 32'h99; tbl[7].bsel = 3; tbl[7].si = 32'h7F;
        tbl[7].exp_a = 32'h0; tbl[7].exp_b = 32'h7F;
        tbl[8] = base(); tbl[8].rs1 = 9; tbl[8].bsel = 4; tbl[8].sbi = 32'hFFFFFFF0;
        tbl[8].exp_a = 9; tbl[8].exp_b = 32'hFFFFFFF0;
        tbl[9] = base(); tbl[9].bsel = 6; tbl[9].rs2 = 32'h5A; tbl[9].exp_b = 0; tbl[9].exp_sd = 32'h5A;
        tbl[10] = base(); tbl[10].bsel = 7; tbl[10].rs2 = 32'hA5; tbl[10].exp_b = 0; tbl[10].exp_sd = 32'hA5;
        tbl[11] = base(); tbl[11].rs2a = 5; tbl[11].rs2 = 32'h66; tbl[11].bsel = 1; tbl[11].ii = 1;
        tbl[11].fv = 2'b10; tbl[11].fa = {5'd5, 5'd0}; tbl[11].fd = {32'h55, 32'h0};
        tbl[11].exp_b = 1; tbl[11].exp_sd = 32'h55;

        // Reset state
        #2;
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.A", operand_A, 32'd0);
        check("rst.pc", out_pc, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Back-to-back directed stream: each vector must appear exactly one cycle later
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_vec(tbl[i]); in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            check_out($sformatf("tbl%0d", i), tbl[i]);
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain.valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: X held while Y waits; then Y appears once
        @(negedge clk); drive_vec(tbl[0]); in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); drive_vec(tbl[4]);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp.in_ready%0d", c), {31'd0, in_ready}, (CAP == 2 && c == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            check_out($sformatf("bp.hold%0d", c), tbl[0]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_out("bp.next", tbl[4]);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp.nodup", {31'd0, out_valid}, 32'd0);

        // Flush beats a simultaneous load
        @(negedge clk); drive_vec(tbl[0]); in_valid = 1'b1;
        @(posedge clk); #1;
        check_out("fl.pre", tbl[0]);
        @(negedge clk); drive_vec(tbl[4]); flush = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        check("fl.valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("fl.dropped", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while holding a valid output
        @(negedge clk); drive_vec(tbl[1]); in_valid = 1'b1;
        @(posedge clk); #1;
        check_out("ar.pre", tbl[1]);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar.valid", {31'd0, out_valid}, 32'd0);
        check("ar.A", operand_A, 32'd0);
        check("ar.B", operand_B, 32'd0);
        check("ar.sd", store_data, 32'd0);
        check("ar.pc", out_pc, 32'd0);
        check("ar.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        drive_vec(tbl[4]); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check_out("ar.post", tbl[4]);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        check("ar.drain", {31'd0, out_valid}, 32'd0);

        // Randomized traffic against an occupancy-queue model
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            operand_ASel = 2'($urandom_range(0, 3));
            operand_BSel = 3'($urandom_range(0, 7));
            pc = $urandom; rs1 = $urandom; rs2 = $urandom;
            rs1_addr = 5'($urandom_range(0, 5)); rs2_addr = 5'($urandom_range(0, 5));
            itype_imm = $urandom; utype_imm = $urandom; stype_imm = $urandom;
            sbtype_imm = $urandom; ujtype_imm = $urandom;
            fwd_valid = 2'($urandom); fwd_addr = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
            fwd_data = {$urandom, $urandom};
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 24) == 0);
            m_ready = (CAP == 2) ? (mq.size() < 2) : (mq.size() == 0 || out_ready);
            #1;
            check("rnd.in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            m_push = in_valid && m_ready && !flush;
            f = ref_ops();
            @(posedge clk);
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (m_push) mq.push_back(f);
            end
            #1;
            check("rnd.valid", {31'd0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
            if (mq.size() > 0) begin
                check("rnd.A", operand_A, mq[0].a);
                check("rnd.B", operand_B, mq[0].b);
                check("rnd.sd", store_data, mq[0].sd);
                check("rnd.pc", out_pc, mq[0].pc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
